add_digit_serial: RTL

- Parametrised, multi-cycle successor to the team's fixed 8-bit combinational ripple adder.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, using one DIGIT-bit adder slice and a registered carry.
- Returns a modulo-2^WIDTH result, plus carry-out and signed overflow, which the 8-bit block does not provide.
- Valid/ready on both sides, so it can sit in datapaths where area matters more than latency.

---
 rtl/add_digit_serial.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/add_digit_serial.sv
// Digit-serial WIDTH-bit add/subtract, one DIGIT-bit slice per cycle; out_valid NSTEP cycles after capture.
// Strictly one operation in flight: in_ready only in IDLE; result holds in DONE until out_ready is sampled high.
module add_digit_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTEP = WIDTH / ((DIGIT < 1) ? 1 : DIGIT);
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) ||
      ((WIDTH % ((DIGIT < 1) ? 1 : DIGIT)) != 0)) begin : g_bad_param
    $error("add_digit_serial: need 1 <= DIGIT <= WIDTH and WIDTH %% DIGIT == 0");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [SW-1:0]    r_step;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_slice;
  logic             w_last;
  logic             w_msb_cin;

  // Operands shift right each RUN cycle so the active digit always sits at bit 0.
  assign w_a_dig   = r_a[DIGIT-1:0];
  assign w_b_dig   = r_b[DIGIT-1:0];
  assign w_slice   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
  assign w_last    = (r_step == SW'(NSTEP - 1));
  // Carry into the slice's top bit, recovered from that bit's sum; equals carry into MSB on the last step.
  assign w_msb_cin = w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1] ^ w_slice[DIGIT-1];

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_step  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_step  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        S_RUN: begin
          r_sum[r_step*DIGIT +: DIGIT] <= w_slice[DIGIT-1:0];
          r_carry <= w_slice[DIGIT];
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          if (w_last) begin
            r_cout <= w_slice[DIGIT];
            r_ovf  <= w_msb_cin ^ w_slice[DIGIT];
            r_step <= '0;
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
